muller_c_hs_monitor: RTL and testbench
======================================

Name: muller_c_hs_monitor

Overview:
- Clocked observer directly downstream of the Muller C-element in the muller_c_proj user project.
- Samples the element's two asynchronous inputs (a, b) and its output (c) through 2-flop synchronisers.
- Checks 4-phase protocol legality, counts completed handshakes and reports a sticky error code.
- Outputs feed the project's io_out/logic-analyser pins for silicon bring-up.

Parameters:
- CNT_W, 16, handshake counter width in bits (≥2).
- TIMEOUT_CYC, 1024, stall threshold in clock cycles (used only with MULLER_MON_TIMEOUT_EN).

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  synchronous active-high reset.
- a_i  in  1  C-element input A (asynchronous).
- b_i  in  1  C-element input B (asynchronous).
- c_i  in  1  C-element output (asynchronous).
- clr_i  in  1  synchronous clear of counter, wrap flag and error.
- hs_done_o  out  1  one-cycle pulse per completed handshake.
- hs_count_o  out  CNT_W  completed handshake count.
- wrap_o  out  1  sticky; set when hs_count_o wraps max→0.
- err_o  out  1  sticky protocol error.
- err_code_o  out  2  0 none, 1 BAD_RISE, 2 BAD_FALL, 3 STALL.
- state_o  out  2  FSM state: 0 LOW, 1 HIGH, 2 ERR.

Behaviour:
- Reset (wb_rst_i high at posedge): all synchroniser flops 0, state LOW, hs_count_o 0, hs_done_o 0, wrap_o 0, err_o 0, err_code_o 0. Reset has priority over clr_i and all events.
- Synchronisers: a_s, b_s, c_s are the second flop of each 2-flop chain. The FSM acts only on a_s, b_s, c_s.
- Latency: an input change captured at edge k appears on *_s after edge k+1. The FSM registers its reaction at edge k+2. hs_done_o is therefore high for exactly the one cycle after edge k+2.
- State LOW (C output low):
  - c_s=1 with a_s&b_s=1 → HIGH.
  - c_s=1 otherwise → ERR, code BAD_RISE.
  - a_s≠b_s or a_s=b_s=1 with c_s=0 → stay in LOW (legal pending).
- State HIGH (C output high):
  - c_s=0 with a_s|b_s=0 → LOW, hs_done_o=1, hs_count_o+1.
  - c_s=0 otherwise → ERR, code BAD_FALL.
- State ERR:
  - Held until clr_i or reset. Counter frozen, hs_done_o 0.
  - err_o=1 and err_code_o hold the first error only. Later violations are ignored.
- Counter: modulo 2^CNT_W. An increment from all-ones gives 0 and sets wrap_o.
- clr_i at a posedge, without reset:
  - hs_count_o←0, wrap_o←0, err_o←0, err_code_o←0.
  - state←(c_s ? HIGH : LOW). No handshake completion or error is recorded that cycle.
  - clr_i wins over a simultaneous FSM event.
- Glitch rule: a c_s pulse of 1 cycle is handled like any other level change. No filtering.
- No combinational path from any input to any output. All outputs are registered.

Optional Feature:
- Macro: MULLER_MON_TIMEOUT_EN.
- When defined:
  - A counter of ceil(log2(TIMEOUT_CYC+1)) bits runs while state=LOW, a_s=b_s=1 and c_s=0. Any other condition clears it to 0.
  - When the counter reaches TIMEOUT_CYC → ERR, code STALL.
  - The counter is cleared by reset and by clr_i.
- When undefined: no timer logic, and code 3 is never produced.

Decomposition:
- Package muller_mon_pkg: state enum (LOW=0, HIGH=1, ERR=2), error-code constants (ERR_NONE, ERR_BAD_RISE, ERR_BAD_FALL, ERR_STALL), default CNT_W.
- One sub-module: muller_sync2. 2-flop synchroniser with synchronous active-high reset to 0, instantiated three times.

Test Plan:
- Legal handshake: a=b=0,c=0 → a=1 → b=1 → c=1 → a=0,b=0 → c=0 (≥4 cycles per step). Required: hs_done_o pulses once, exactly 3 edges after c falls; hs_count_o=1; err_o=0.
- BAD_RISE: a=1, b=0, then c=1. Required: state_o=2, err_o=1, err_code_o=1; a following legal handshake leaves hs_count_o unchanged.
- BAD_FALL: reach HIGH legally, then c=0 while b=1. Required: err_code_o=2. Then clr_i=1 for one cycle with c=0 → state_o=0, err_o=0, hs_count_o=0.
- Wrap: CNT_W=2, run 4 legal handshakes. Required: hs_count_o sequence 1,2,3,0 and wrap_o=1 after the 4th.
- Reset mid-operation: assert wb_rst_i while in HIGH with count=5. Required: next cycle all outputs 0 and state_o=0; the next legal handshake gives count=1.
- MULLER_MON_TIMEOUT_EN, TIMEOUT_CYC=8: hold a=b=1, c=0 for 20 cycles. Required: err_code_o=3. Same stimulus without the macro → err_o stays 0.

Source files
------------

// File: rtl/muller_mon_pkg.sv
// Shared types and constants for the Muller C-element handshake monitor.
package muller_mon_pkg;

  // Monitor FSM state; the encoding is visible on state_o.
  typedef enum logic [1:0] {
    StLow  = 2'd0,
    StHigh = 2'd1,
    StErr  = 2'd2
  } mon_state_e;

  // Values reported on err_code_o.
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BAD_RISE = 2'd1;
  localparam logic [1:0] ERR_BAD_FALL = 2'd2;
  localparam logic [1:0] ERR_STALL    = 2'd3;

  localparam int unsigned CNT_W_DEFAULT = 16;

endpackage

// File: rtl/muller_sync2.sv
// Two-flop synchroniser for one asynchronous bit, synchronous active-high reset to 0.
module muller_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; second flop gives the settled value.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/muller_c_hs_monitor.sv
// Clocked 4-phase protocol monitor for a Muller C-element (inputs a, b; output c).
// Counts completed handshakes and latches the first protocol error.
// Optional stall detection is enabled with the MULLER_MON_TIMEOUT_EN macro.
module muller_c_hs_monitor
  import muller_mon_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             c_i,
  input  logic             clr_i,
  output logic             hs_done_o,
  output logic [CNT_W-1:0] hs_count_o,
  output logic             wrap_o,
  output logic             err_o,
  output logic [1:0]       err_code_o,
  output logic [1:0]       state_o
);

  // Elaboration-time parameter sanity checks.
  if (CNT_W < 2) begin : g_bad_cnt_w
    $error("CNT_W must be at least 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  logic a_s, b_s, c_s;

  muller_sync2 u_sync_a (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d   (a_i),
    .q   (a_s)
  );

  muller_sync2 u_sync_b (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d   (b_i),
    .q   (b_s)
  );

  muller_sync2 u_sync_c (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d   (c_i),
    .q   (c_s)
  );

  mon_state_e       state;
  logic             hs_done;
  logic [CNT_W-1:0] hs_count;
  logic             wrap;
  logic             err;
  logic [1:0]       err_code;

`ifdef MULLER_MON_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] timer;
  logic          stall_cond;

  // Both inputs high but C has not fired: the element is waiting to rise.
  assign stall_cond = (state == StLow) && a_s && b_s && !c_s;
`endif

  // Protocol FSM with counter, sticky flags and stall timer; clr_i beats any FSM event.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= StLow;
      hs_done  <= 1'b0;
      hs_count <= '0;
      wrap     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
`ifdef MULLER_MON_TIMEOUT_EN
      timer    <= '0;
`endif
    end else if (clr_i) begin
      // Resynchronise to the current C level without recording anything.
      state    <= c_s ? StHigh : StLow;
      hs_done  <= 1'b0;
      hs_count <= '0;
      wrap     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
`ifdef MULLER_MON_TIMEOUT_EN
      timer    <= '0;
`endif
    end else begin
      hs_done <= 1'b0;
`ifdef MULLER_MON_TIMEOUT_EN
      timer   <= stall_cond ? timer + 1'b1 : '0;
`endif
      case (state)
        StLow: begin
          if (c_s) begin
            if (a_s && b_s) begin
              state <= StHigh;
            end else begin
              state    <= StErr;
              err      <= 1'b1;
              err_code <= ERR_BAD_RISE;
            end
`ifdef MULLER_MON_TIMEOUT_EN
          end else if (stall_cond && (timer == TW'(TIMEOUT_CYC - 1))) begin
            // Timer reaches TIMEOUT_CYC on this edge.
            state    <= StErr;
            err      <= 1'b1;
            err_code <= ERR_STALL;
`endif
          end
        end
        StHigh: begin
          if (!c_s) begin
            if (!a_s && !b_s) begin
              state    <= StLow;
              hs_done  <= 1'b1;
              hs_count <= hs_count + 1'b1;
              if (&hs_count) begin
                wrap <= 1'b1;
              end
            end else begin
              state    <= StErr;
              err      <= 1'b1;
              err_code <= ERR_BAD_FALL;
            end
          end
        end
        default: begin
          // StErr: frozen until clr_i or reset; later violations are ignored.
          state <= StErr;
        end
      endcase
    end
  end

  assign hs_done_o  = hs_done;
  assign hs_count_o = hs_count;
  assign wrap_o     = wrap;
  assign err_o      = err;
  assign err_code_o = err_code;
  assign state_o    = state;

endmodule

// File: tb/tb_muller_c_hs_monitor.sv
// Directed bench for muller_c_hs_monitor: a 16-bit counter instance and a 2-bit one
// (for wrap) share the same stimulus.
module tb_muller_c_hs_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic a = 1'b0;
  logic b = 1'b0;
  logic c = 1'b0;

  logic        d1_done, d1_wrap, d1_err;
  logic [15:0] d1_count;
  logic [1:0]  d1_code, d1_state;

  logic        d2_done, d2_wrap, d2_err;
  logic [1:0]  d2_count;
  logic [1:0]  d2_code, d2_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muller_c_hs_monitor #(
    .CNT_W       (16),
    .TIMEOUT_CYC (8)
  ) u_dut1 (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .a_i        (a),
    .b_i        (b),
    .c_i        (c),
    .clr_i      (clr),
    .hs_done_o  (d1_done),
    .hs_count_o (d1_count),
    .wrap_o     (d1_wrap),
    .err_o      (d1_err),
    .err_code_o (d1_code),
    .state_o    (d1_state)
  );

  muller_c_hs_monitor #(
    .CNT_W       (2),
    .TIMEOUT_CYC (8)
  ) u_dut2 (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .a_i        (a),
    .b_i        (b),
    .c_i        (c),
    .clr_i      (clr),
    .hs_done_o  (d2_done),
    .hs_count_o (d2_count),
    .wrap_o     (d2_wrap),
    .err_o      (d2_err),
    .err_code_o (d2_code),
    .state_o    (d2_state)
  );

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One legal 4-phase handshake from an all-low idle, 4 cycles per step.
  task automatic do_hs();
    a = 1'b1; tick(4);
    b = 1'b1; tick(4);
    c = 1'b1; tick(4);
    a = 1'b0; b = 1'b0; tick(4);
    c = 1'b0; tick(4);
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0;
    tick(3);
    checks++; if (d1_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", d1_state); end
    checks++; if (d1_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", d1_count); end
    checks++; if (d1_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", d1_done); end
    checks++; if (d1_wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b want 0", d1_wrap); end
    checks++; if (d1_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", d1_err); end
    checks++; if (d1_code !== 2'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", d1_code); end
    checks++; if (d2_count !== 2'd0) begin errors++; $display("FAIL reset_count2: got %0d want 0", d2_count); end
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_legal_hs();
    a = 1'b1; tick(4);
    b = 1'b1; tick(4);
    c = 1'b1; tick(4);
    checks++; if (d1_state !== 2'd1) begin errors++; $display("FAIL legal_high: got %0d want 1", d1_state); end
    a = 1'b0; b = 1'b0; tick(4);
    c = 1'b0;
    tick(1);
    checks++; if (d1_done !== 1'b0) begin errors++; $display("FAIL legal_done_e1: got %b want 0", d1_done); end
    tick(1);
    checks++; if (d1_done !== 1'b0) begin errors++; $display("FAIL legal_done_e2: got %b want 0", d1_done); end
    tick(1);
    checks++; if (d1_done !== 1'b1) begin errors++; $display("FAIL legal_done_e3: got %b want 1", d1_done); end
    checks++; if (d1_count !== 16'd1) begin errors++; $display("FAIL legal_count: got %0d want 1", d1_count); end
    tick(1);
    checks++; if (d1_done !== 1'b0) begin errors++; $display("FAIL legal_done_e4: got %b want 0", d1_done); end
    checks++; if (d1_err !== 1'b0) begin errors++; $display("FAIL legal_err: got %b want 0", d1_err); end
    checks++; if (d1_state !== 2'd0) begin errors++; $display("FAIL legal_low: got %0d want 0", d1_state); end
    checks++; if (d2_count !== 2'd1) begin errors++; $display("FAIL legal_count2: got %0d want 1", d2_count); end
    tick(4);
  endtask

  task automatic test_bad_rise();
    a = 1'b1; tick(4);
    c = 1'b1; tick(4);
    checks++; if (d1_state !== 2'd2) begin errors++; $display("FAIL rise_state: got %0d want 2", d1_state); end
    checks++; if (d1_err !== 1'b1) begin errors++; $display("FAIL rise_err: got %b want 1", d1_err); end
    checks++; if (d1_code !== 2'd1) begin errors++; $display("FAIL rise_code: got %0d want 1", d1_code); end
    c = 1'b0; a = 1'b0; tick(4);
    do_hs();
    checks++; if (d1_count !== 16'd1) begin errors++; $display("FAIL rise_frozen_count: got %0d want 1", d1_count); end
    checks++; if (d1_code !== 2'd1) begin errors++; $display("FAIL rise_code_held: got %0d want 1", d1_code); end
    checks++; if (d1_state !== 2'd2) begin errors++; $display("FAIL rise_state_held: got %0d want 2", d1_state); end
  endtask

  task automatic test_bad_fall();
    clr = 1'b1; tick(1); clr = 1'b0;
    checks++; if (d1_state !== 2'd0) begin errors++; $display("FAIL clr1_state: got %0d want 0", d1_state); end
    checks++; if (d1_err !== 1'b0) begin errors++; $display("FAIL clr1_err: got %b want 0", d1_err); end
    tick(4);
    a = 1'b1; b = 1'b1; tick(4);
    c = 1'b1; tick(4);
    checks++; if (d1_state !== 2'd1) begin errors++; $display("FAIL fall_high: got %0d want 1", d1_state); end
    a = 1'b0; tick(4);
    c = 1'b0; tick(4);
    checks++; if (d1_state !== 2'd2) begin errors++; $display("FAIL fall_state: got %0d want 2", d1_state); end
    checks++; if (d1_code !== 2'd2) begin errors++; $display("FAIL fall_code: got %0d want 2", d1_code); end
    checks++; if (d1_err !== 1'b1) begin errors++; $display("FAIL fall_err: got %b want 1", d1_err); end
    b = 1'b0; tick(4);
    clr = 1'b1; tick(1); clr = 1'b0;
    checks++; if (d1_state !== 2'd0) begin errors++; $display("FAIL clr2_state: got %0d want 0", d1_state); end
    checks++; if (d1_err !== 1'b0) begin errors++; $display("FAIL clr2_err: got %b want 0", d1_err); end
    checks++; if (d1_code !== 2'd0) begin errors++; $display("FAIL clr2_code: got %0d want 0", d1_code); end
    checks++; if (d1_count !== 16'd0) begin errors++; $display("FAIL clr2_count: got %0d want 0", d1_count); end
    tick(4);
  endtask

  task automatic test_wrap();
    logic [1:0] exp_cnt [4];
    logic       exp_wrap [4];
    exp_cnt  = '{2'd1, 2'd2, 2'd3, 2'd0};
    exp_wrap = '{1'b0, 1'b0, 1'b0, 1'b1};
    rst = 1'b1; tick(2); rst = 1'b0; tick(2);
    for (int i = 0; i < 4; i++) begin
      do_hs();
      checks++;
      if (d2_count !== exp_cnt[i]) begin
        errors++; $display("FAIL wrap_count%0d: got %0d want %0d", i, d2_count, exp_cnt[i]);
      end
      checks++;
      if (d2_wrap !== exp_wrap[i]) begin
        errors++; $display("FAIL wrap_flag%0d: got %b want %b", i, d2_wrap, exp_wrap[i]);
      end
    end
    checks++; if (d1_count !== 16'd4) begin errors++; $display("FAIL wrap_count16: got %0d want 4", d1_count); end
  endtask

  task automatic test_reset_mid();
    do_hs();
    a = 1'b1; b = 1'b1; tick(4);
    c = 1'b1; tick(4);
    checks++; if (d1_state !== 2'd1) begin errors++; $display("FAIL rmid_high: got %0d want 1", d1_state); end
    checks++; if (d1_count !== 16'd5) begin errors++; $display("FAIL rmid_count5: got %0d want 5", d1_count); end
    rst = 1'b1; a = 1'b0; b = 1'b0; c = 1'b0;
    tick(1);
    checks++; if (d1_state !== 2'd0) begin errors++; $display("FAIL rmid_state: got %0d want 0", d1_state); end
    checks++; if (d1_count !== 16'd0) begin errors++; $display("FAIL rmid_count: got %0d want 0", d1_count); end
    checks++; if (d1_done !== 1'b0) begin errors++; $display("FAIL rmid_done: got %b want 0", d1_done); end
    checks++; if (d1_err !== 1'b0) begin errors++; $display("FAIL rmid_err: got %b want 0", d1_err); end
    checks++; if (d1_code !== 2'd0) begin errors++; $display("FAIL rmid_code: got %0d want 0", d1_code); end
    checks++; if (d2_wrap !== 1'b0) begin errors++; $display("FAIL rmid_wrap2: got %b want 0", d2_wrap); end
    rst = 1'b0; tick(4);
    do_hs();
    checks++; if (d1_count !== 16'd1) begin errors++; $display("FAIL rmid_next_count: got %0d want 1", d1_count); end
  endtask

  task automatic test_timeout();
    a = 1'b1; b = 1'b1; c = 1'b0;
    tick(20);
`ifdef MULLER_MON_TIMEOUT_EN
    checks++; if (d1_code !== 2'd3) begin errors++; $display("FAIL stall_code: got %0d want 3", d1_code); end
    checks++; if (d1_err !== 1'b1) begin errors++; $display("FAIL stall_err: got %b want 1", d1_err); end
    checks++; if (d1_state !== 2'd2) begin errors++; $display("FAIL stall_state: got %0d want 2", d1_state); end
`else
    checks++; if (d1_err !== 1'b0) begin errors++; $display("FAIL nostall_err: got %b want 0", d1_err); end
    checks++; if (d1_state !== 2'd0) begin errors++; $display("FAIL nostall_state: got %0d want 0", d1_state); end
    checks++; if (d1_code !== 2'd0) begin errors++; $display("FAIL nostall_code: got %0d want 0", d1_code); end
`endif
    a = 1'b0; b = 1'b0; tick(4);
  endtask

  initial begin
    test_reset();
    test_legal_hs();
    test_bad_rise();
    test_bad_fall();
    test_wrap();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
